acc_req_sender: RTL and testbench
=================================

ACC_REQ_SENDER -- requirements
Module: acc_req_sender

Interface
REQ-001 Parameter DEPTH, default 4, number of buffered accumulate requests (power of two, >=2).
REQ-002 Parameter N_ACC, default package N_ACC (3), number of parent accumulator registers.
REQ-003 clk  input  1  clock; all state updates on posedge clk.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 enq_valid  input  1  core commits an accumulate instruction this cycle.
REQ-006 enq_acc  input  2  target accumulator index.
REQ-007 enq_data  input  32  float operand to add into the accumulator.
REQ-008 enq_ready  output  1  buffer can accept an entry.
REQ-009 acc_req_valid  output  1 x N_ACC  request to parent accumulator i.
REQ-010 acc_req_ready  input  1 x N_ACC  parent grants accumulator i this cycle.
REQ-011 acc_data  output  32 x N_ACC  operand presented to accumulator i.
REQ-012 empty  output  1  no request is buffered or pending (used for fork/join drain).
REQ-013 stall_cycles  output  8  saturating count of cycles the current head has waited.

Function
REQ-014 Buffering: in-order FIFO of DEPTH entries {acc index, data}. An entry is accepted on any cycle with enq_valid && enq_ready && enq_acc < N_ACC.
REQ-015 enq_ready = (count < DEPTH). There is no pass-through when full, even if a dequeue occurs in the same cycle.
REQ-016 An enq_acc >= N_ACC is discarded: nothing is written and count is unchanged.
REQ-017 Only the head entry is presented: acc_req_valid[head.acc] = 1 when count > 0. All other valid bits are 0, so at most one bit is set.
REQ-018 acc_data[i] = head.data for every i. acc_data is don't-care where valid is 0, but it is driven with head.data and not X.
REQ-019 Dequeue occurs when acc_req_valid[k] && acc_req_ready[k] for the head's k. The next entry is presented in the following cycle, so the sustained rate is 1 request/cycle.
REQ-020 valid and data for the head are held stable until it is accepted; there is no withdrawal.
REQ-021 Latency: an entry written at edge t into an empty FIFO drives acc_req_valid from cycle t+1 (registered storage, combinational head decode).
REQ-022 Simultaneous enqueue and dequeue: count is unchanged; head and tail pointers both advance.
REQ-023 Pointers are log2(DEPTH) bits and wrap modulo DEPTH. count is log2(DEPTH)+1 bits and ranges 0..DEPTH.
REQ-024 empty = (count == 0).
REQ-025 stall_cycles behaviour:
- clears to 0 on every dequeue and whenever count == 0;
- otherwise increments each cycle the head is not accepted;
- saturates at 255.
REQ-026 acc_req_ready bits for indices other than the head's index are ignored.

Reset
REQ-027 On reset: head, tail and count are set to 0 and stall_cycles to 0. All buffered entries are discarded.
REQ-028 After the reset edge: acc_req_valid = all 0, empty = 1, enq_ready = 1, stall_cycles = 0, acc_data = 0 (storage cleared).
REQ-029 reset takes priority over a simultaneous enqueue or dequeue: neither takes effect.
REQ-030 A reset in mid-operation withdraws any pending request. The parent tolerates this because its arbitration is combinational per cycle.

Structure
REQ-031 N_ACC, N_CORE and the FLOAT32 data width live in the shared common package. The entry struct type acc_req_t {acc index, data} is added to that package.
REQ-032 Storage and pointers are factored into one sub-module, acc_req_fifo (DEPTH, payload acc_req_t, outputs full/empty/count). acc_req_sender adds the index decode, the invalid-index filter and the stall counter.
REQ-033 One instance per child core. Outputs connect to the parent's acc_req_valid[core][*] and acc_data[core][*].

Verification
REQ-034 Single request: enq acc=1, data=0x3F800000 with ready low for 3 cycles, then high.
- Expected: acc_req_valid=3'b010 from t+1 with data stable; stall_cycles reaches 3; dequeue on the 4th cycle; then empty=1.
REQ-035 Fill and backpressure: enqueue 5 back-to-back entries with all ready=0.
- Expected: enq_ready drops after the 4th entry and the 5th is not accepted.
- Then ready=3'b111: four requests in order, one per cycle, and empty rises after the 4th.
REQ-036 Simultaneous events: at count=2, enqueue while the head is accepted.
- Expected: count stays 2; order preserved across pointer wrap over 10 entries.
REQ-037 Invalid index: enq acc=3 followed by enq acc=0, data=0x40000000.
- Expected: only acc_req_valid=3'b001 with 0x40000000 appears.
REQ-038 Reset mid-operation: 3 entries buffered, ready=0, reset asserted 1 cycle.
- Expected: next cycle acc_req_valid=0, empty=1, enq_ready=1, stall_cycles=0.
REQ-039 Saturation: hold ready=0 for 300 cycles with one entry buffered.
- Expected: stall_cycles=255 and holds; it clears the cycle after acceptance.

Source files
------------

// File: rtl/acc_req_sender_pkg.sv
`default_nettype none
// ============================================================================
// Module  : acc_req_sender_pkg
// Brief   : Shared constants and the accumulate-request entry type.
// Revision: 1.0 - initial release
// ============================================================================
package acc_req_sender_pkg;

  localparam int N_ACC     = 3;
  localparam int N_CORE    = 4;
  localparam int FLOAT32_W = 32;
  localparam int ACC_IDX_W = 2;

  typedef struct packed {
    logic [ACC_IDX_W-1:0] acc;
    logic [FLOAT32_W-1:0] data;
  } acc_req_t;

  function automatic logic idx_in_range(input logic [ACC_IDX_W-1:0] idx, input int n);
    return int'(idx) < n;
  endfunction

endpackage
`default_nettype wire

// File: rtl/acc_req_sender_if.sv
`default_nettype none
// ============================================================================
// Module  : acc_req_sender_if
// Brief   : Core-side enqueue and parent-side accumulator request bundle.
// Revision: 1.0 - initial release
// ============================================================================
interface acc_req_sender_if #(
  parameter int N_ACC = acc_req_sender_pkg::N_ACC
);
  import acc_req_sender_pkg::*;

  logic                                 enq_valid;
  logic [ACC_IDX_W-1:0]                 enq_acc;
  logic [FLOAT32_W-1:0]                 enq_data;
  logic                                 enq_ready;
  logic [N_ACC-1:0]                     acc_req_valid;
  logic [N_ACC-1:0]                     acc_req_ready;
  logic [N_ACC-1:0][FLOAT32_W-1:0]      acc_data;
  logic                                 empty;
  logic [7:0]                           stall_cycles;

  // The sender is the request master towards the parent accumulators.
  modport master (
    input  enq_valid, enq_acc, enq_data, acc_req_ready,
    output enq_ready, acc_req_valid, acc_data, empty, stall_cycles
  );

  modport slave (
    output enq_valid, enq_acc, enq_data, acc_req_ready,
    input  enq_ready, acc_req_valid, acc_data, empty, stall_cycles
  );

endinterface
`default_nettype wire

// File: rtl/acc_req_fifo.sv
`default_nettype none
// ============================================================================
// Module  : acc_req_fifo
// Brief   : In-order request FIFO with registered storage and combinational head.
// Revision: 1.0 - initial release
// ============================================================================
module acc_req_fifo
  import acc_req_sender_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  wire logic                     clk,
  input  wire logic                     reset,
  input  wire logic                     i_push,
  input  wire acc_req_t                 i_data,
  input  wire logic                     i_pop,
  output acc_req_t                      o_head,
  output logic                          o_full,
  output logic                          o_empty,
  output logic [$clog2(DEPTH):0]        o_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] C_DEPTH = (PTR_W+1)'(DEPTH);

  acc_req_t         r_mem [DEPTH];
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [PTR_W:0]   r_count;
  logic             w_push;
  logic             w_pop;

  // A full FIFO refuses the push even when the head leaves in the same cycle.
  assign w_push = i_push && !o_full;
  assign w_pop  = i_pop  && !o_empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_push) begin
        r_mem[r_tail] <= i_data;
        r_tail        <= r_tail + PTR_W'(1);
      end
      if (w_pop) begin
        r_head <= r_head + PTR_W'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + (PTR_W+1)'(1);
      end else if (!w_push && w_pop) begin
        r_count <= r_count - (PTR_W+1)'(1);
      end
    end
  end

  assign o_head  = r_mem[r_head];
  assign o_full  = (r_count == C_DEPTH);
  assign o_empty = (r_count == '0);
  assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/acc_req_sender.sv
`default_nettype none
// ============================================================================
// Module  : acc_req_sender
// Brief   : Buffers per-core accumulate requests and presents the head to its parent.
// Revision: 1.0 - initial release
// ============================================================================
module acc_req_sender #(
  parameter int DEPTH = 4,
  parameter int N_ACC = acc_req_sender_pkg::N_ACC
) (
  input  wire logic         clk,
  input  wire logic         reset,
  acc_req_sender_if.master  bus
);
  import acc_req_sender_pkg::*;

  localparam int          CNT_W       = $clog2(DEPTH) + 1;
  localparam logic [7:0]  C_STALL_MAX = 8'hFF;

  acc_req_t          w_enq_entry;
  acc_req_t          w_head;
  logic              w_enq_ok;
  logic              w_deq;
  logic              w_full;
  logic              w_empty;
  logic [CNT_W-1:0]  w_count;
  logic [N_ACC-1:0]  w_valid;
  logic [7:0]        r_stall;

  // Out-of-range accumulator indices never enter the FIFO.
  assign w_enq_ok         = bus.enq_valid && idx_in_range(bus.enq_acc, N_ACC);
  assign w_enq_entry.acc  = bus.enq_acc;
  assign w_enq_entry.data = bus.enq_data;

  acc_req_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_enq_ok),
    .i_data  (w_enq_entry),
    .i_pop   (w_deq),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  always_comb begin
    w_valid = '0;
    if (!w_empty) begin
      for (int i = 0; i < N_ACC; i++) begin
        w_valid[i] = (w_head.acc == ACC_IDX_W'(i));
      end
    end
  end

  // Only the head's own ready bit can complete the handshake.
  assign w_deq = |(w_valid & bus.acc_req_ready);

  generate
    for (genvar gi = 0; gi < N_ACC; gi++) begin : g_acc_data
      assign bus.acc_data[gi] = w_head.data;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall <= '0;
    end else if (w_deq || (w_count == '0)) begin
      r_stall <= '0;
    end else if (r_stall != C_STALL_MAX) begin
      r_stall <= r_stall + 8'd1;
    end
  end

  assign bus.enq_ready     = !w_full;
  assign bus.empty         = w_empty;
  assign bus.acc_req_valid = w_valid;
  assign bus.stall_cycles  = r_stall;

endmodule
`default_nettype wire

// File: tb/tb_acc_req_sender.sv
`default_nettype none
// ============================================================================
// Module  : tb_acc_req_sender
// Brief   : Scoreboard bench for acc_req_sender.
// Revision: 1.0 - initial release
// ============================================================================
module tb_acc_req_sender;
  import acc_req_sender_pkg::*;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  acc_req_sender_if #(.N_ACC(N_ACC)) bus ();

  acc_req_sender #(
    .DEPTH (DEPTH),
    .N_ACC (N_ACC)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  acc_req_t sb[$];
  int       m_stall;
  int       n_tests;
  int       n_fail;

  function automatic logic [N_ACC-1:0] exp_valid();
    logic [N_ACC-1:0] v;
    v = '0;
    if (sb.size() > 0) v[sb[0].acc] = 1'b1;
    return v;
  endfunction

  // Drive one cycle of stimulus from a negedge and advance the reference model.
  task automatic step(input logic ev, input logic [1:0] acc, input logic [31:0] d,
                      input logic [N_ACC-1:0] rdy);
    acc_req_t e;
    logic deq, enq;
    bus.enq_valid     = ev;
    bus.enq_acc       = acc;
    bus.enq_data      = d;
    bus.acc_req_ready = rdy;
    @(posedge clk);
    deq = (sb.size() > 0) && rdy[sb[0].acc];
    enq = ev && (sb.size() < DEPTH) && (int'(acc) < N_ACC);
    if (deq || sb.size() == 0) m_stall = 0;
    else if (m_stall < 255) m_stall++;
    if (deq) void'(sb.pop_front());
    if (enq) begin
      e.acc = acc; e.data = d;
      sb.push_back(e);
    end
    @(negedge clk);
  endtask

  task automatic pulse_reset(input logic ev, input logic [N_ACC-1:0] rdy);
    reset = 1'b1;
    bus.enq_valid = ev; bus.enq_acc = 2'd0; bus.enq_data = 32'hCAFE_0000;
    bus.acc_req_ready = rdy;
    @(posedge clk);
    sb.delete();
    m_stall = 0;
    @(negedge clk);
    reset = 1'b0;
    bus.enq_valid = 1'b0;
    bus.acc_req_ready = '0;
  endtask

  task automatic test_reset();
    pulse_reset(1'b1, '1);
    pulse_reset(1'b1, '1);
    n_tests++; if (bus.acc_req_valid !== 3'b000) begin n_fail++; $display("FAIL reset_valid: got %b expected 000", bus.acc_req_valid); end
    n_tests++; if (bus.empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %b expected 1", bus.empty); end
    n_tests++; if (bus.enq_ready !== 1'b1) begin n_fail++; $display("FAIL reset_enq_ready: got %b expected 1", bus.enq_ready); end
    n_tests++; if (bus.stall_cycles !== 8'd0) begin n_fail++; $display("FAIL reset_stall: got %0d expected 0", bus.stall_cycles); end
    for (int i = 0; i < N_ACC; i++) begin
      n_tests++; if (bus.acc_data[i] !== 32'h0) begin n_fail++; $display("FAIL reset_data[%0d]: got %h expected 0", i, bus.acc_data[i]); end
    end
  endtask

  task automatic test_single();
    step(1'b1, 2'd1, 32'h3F80_0000, 3'b000);
    for (int k = 0; k <= 3; k++) begin
      n_tests++; if (bus.acc_req_valid !== 3'b010) begin n_fail++; $display("FAIL single_valid[%0d]: got %b expected 010", k, bus.acc_req_valid); end
      n_tests++; if (bus.acc_data[1] !== 32'h3F80_0000) begin n_fail++; $display("FAIL single_data[%0d]: got %h expected 3f800000", k, bus.acc_data[1]); end
      n_tests++; if (bus.stall_cycles !== 8'(k)) begin n_fail++; $display("FAIL single_stall[%0d]: got %0d expected %0d", k, bus.stall_cycles, k); end
      if (k < 3) step(1'b0, 2'd0, 32'h0, 3'b000);
    end
    step(1'b0, 2'd0, 32'h0, 3'b010);
    n_tests++; if (bus.empty !== 1'b1) begin n_fail++; $display("FAIL single_empty: got %b expected 1", bus.empty); end
    n_tests++; if (bus.stall_cycles !== 8'd0) begin n_fail++; $display("FAIL single_stall_clr: got %0d expected 0", bus.stall_cycles); end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 5; i++) begin
      n_tests++; if (bus.enq_ready !== (i < 4)) begin n_fail++; $display("FAIL fill_enq_ready[%0d]: got %b expected %b", i, bus.enq_ready, (i < 4)); end
      step(1'b1, 2'(i % 3), 32'h1000 + 32'(i), 3'b000);
    end
    n_tests++; if (bus.enq_ready !== 1'b0) begin n_fail++; $display("FAIL fill_full: got %b expected 0", bus.enq_ready); end
    for (int j = 0; j < 4; j++) begin
      n_tests++; if (bus.acc_req_valid !== exp_valid()) begin n_fail++; $display("FAIL fill_valid[%0d]: got %b expected %b", j, bus.acc_req_valid, exp_valid()); end
      n_tests++; if (bus.acc_data[sb[0].acc] !== sb[0].data) begin n_fail++; $display("FAIL fill_data[%0d]: got %h expected %h", j, bus.acc_data[sb[0].acc], sb[0].data); end
      n_tests++; if (bus.empty !== 1'b0) begin n_fail++; $display("FAIL fill_not_empty[%0d]: got %b expected 0", j, bus.empty); end
      step(1'b0, 2'd0, 32'h0, 3'b111);
    end
    n_tests++; if (bus.empty !== 1'b1) begin n_fail++; $display("FAIL fill_drained: got %b expected 1", bus.empty); end
  endtask

  task automatic test_back_to_back();
    step(1'b1, 2'd0, 32'h2000, 3'b000);
    step(1'b1, 2'd1, 32'h2001, 3'b000);
    for (int i = 0; i < 10; i++) begin
      n_tests++; if (bus.acc_req_valid !== exp_valid()) begin n_fail++; $display("FAIL b2b_valid[%0d]: got %b expected %b", i, bus.acc_req_valid, exp_valid()); end
      n_tests++; if (bus.acc_data[0] !== sb[0].data) begin n_fail++; $display("FAIL b2b_data[%0d]: got %h expected %h", i, bus.acc_data[0], sb[0].data); end
      n_tests++; if (bus.enq_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_enq_ready[%0d]: got %b expected 1", i, bus.enq_ready); end
      step(1'b1, 2'((i + 2) % 3), 32'h2002 + 32'(i), 3'b111);
    end
    for (int j = 0; j < 2; j++) begin
      n_tests++; if (bus.acc_data[2] !== sb[0].data) begin n_fail++; $display("FAIL b2b_tail_data[%0d]: got %h expected %h", j, bus.acc_data[2], sb[0].data); end
      step(1'b0, 2'd0, 32'h0, 3'b111);
    end
    n_tests++; if (bus.empty !== 1'b1) begin n_fail++; $display("FAIL b2b_drained: got %b expected 1", bus.empty); end
  endtask

  task automatic test_invalid_index();
    step(1'b1, 2'd3, 32'hDEAD_BEEF, 3'b000);
    n_tests++; if (bus.empty !== 1'b1) begin n_fail++; $display("FAIL inv_dropped: got empty=%b expected 1", bus.empty); end
    step(1'b1, 2'd0, 32'h4000_0000, 3'b000);
    n_tests++; if (bus.acc_req_valid !== 3'b001) begin n_fail++; $display("FAIL inv_valid: got %b expected 001", bus.acc_req_valid); end
    n_tests++; if (bus.acc_data[0] !== 32'h4000_0000) begin n_fail++; $display("FAIL inv_data: got %h expected 40000000", bus.acc_data[0]); end
    step(1'b0, 2'd0, 32'h0, 3'b001);
    n_tests++; if (bus.empty !== 1'b1) begin n_fail++; $display("FAIL inv_empty: got %b expected 1", bus.empty); end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) step(1'b1, 2'(i), 32'h3000 + 32'(i), 3'b000);
    n_tests++; if (bus.stall_cycles !== 8'd2) begin n_fail++; $display("FAIL mid_stall_pre: got %0d expected 2", bus.stall_cycles); end
    pulse_reset(1'b0, 3'b000);
    n_tests++; if (bus.acc_req_valid !== 3'b000) begin n_fail++; $display("FAIL mid_valid: got %b expected 000", bus.acc_req_valid); end
    n_tests++; if (bus.empty !== 1'b1) begin n_fail++; $display("FAIL mid_empty: got %b expected 1", bus.empty); end
    n_tests++; if (bus.enq_ready !== 1'b1) begin n_fail++; $display("FAIL mid_enq_ready: got %b expected 1", bus.enq_ready); end
    n_tests++; if (bus.stall_cycles !== 8'd0) begin n_fail++; $display("FAIL mid_stall: got %0d expected 0", bus.stall_cycles); end
  endtask

  task automatic test_saturation();
    step(1'b1, 2'd2, 32'h5555_AAAA, 3'b000);
    for (int i = 0; i < 300; i++) begin
      step(1'b0, 2'd0, 32'h0, 3'b011);
      if (i == 100) begin
        n_tests++; if (bus.stall_cycles !== 8'(m_stall)) begin n_fail++; $display("FAIL sat_mid: got %0d expected %0d", bus.stall_cycles, m_stall); end
      end
    end
    n_tests++; if (bus.stall_cycles !== 8'd255) begin n_fail++; $display("FAIL sat_value: got %0d expected 255", bus.stall_cycles); end
    n_tests++; if (bus.acc_data[2] !== 32'h5555_AAAA) begin n_fail++; $display("FAIL sat_data: got %h expected 5555aaaa", bus.acc_data[2]); end
    step(1'b0, 2'd0, 32'h0, 3'b100);
    n_tests++; if (bus.stall_cycles !== 8'd0) begin n_fail++; $display("FAIL sat_clear: got %0d expected 0", bus.stall_cycles); end
    n_tests++; if (bus.empty !== 1'b1) begin n_fail++; $display("FAIL sat_empty: got %b expected 1", bus.empty); end
  endtask

  initial begin
    n_tests = 0; n_fail = 0; m_stall = 0;
    reset = 1'b1;
    bus.enq_valid = 1'b0; bus.enq_acc = '0; bus.enq_data = '0; bus.acc_req_ready = '0;
    @(negedge clk);
    test_reset();
    test_single();
    test_fill();
    test_back_to_back();
    test_invalid_index();
    test_reset_mid();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
